// File: rtl/layered_pixel_compositor.sv
// Three-stage sprite-over-map compositor with frame-latched object registers
// and a rate-limited camera scroll that only moves on the frame_start pulse.
//
// state  | meaning
// IDLE   | camera_offset equals the block target
// SCROLL | camera_offset still approaching the target, one step per frame
module layered_pixel_compositor #(
    parameter int OBJ_NUM      = 8,
    parameter int PHY_WIDTH    = 14,
    parameter int SCREEN_WIDTH = 10,
    parameter int PIXEL_WIDTH  = 12,
    parameter int SIZE_WIDTH   = 6,
    parameter int CAM_WIDTH    = 5,
    parameter int BLOCK_HEIGHT = 480,
    parameter int SCROLL_STEP  = 16
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            frame_start,
    input  logic                            video_on,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic [SCREEN_WIDTH-1:0]         x,
    input  logic [SCREEN_WIDTH-1:0]         y,
    input  logic [CAM_WIDTH-1:0]            camera_blk,
    input  logic [OBJ_NUM*PHY_WIDTH-1:0]    obj_x,
    input  logic [OBJ_NUM*PHY_WIDTH-1:0]    obj_y,
    input  logic [OBJ_NUM*SIZE_WIDTH-1:0]   obj_w,
    input  logic [OBJ_NUM*SIZE_WIDTH-1:0]   obj_h,
    input  logic [OBJ_NUM*PIXEL_WIDTH-1:0]  obj_color,
    input  logic [OBJ_NUM-1:0]              obj_en,
    output logic [SCREEN_WIDTH-1:0]         map_x,
    output logic [PHY_WIDTH-1:0]            map_y,
    input  logic [PIXEL_WIDTH-1:0]          map_rgb,
    output logic [PIXEL_WIDTH-1:0]          rgb,
    output logic                            hsync_out,
    output logic                            vsync_out,
    output logic                            video_on_out,
    output logic [PHY_WIDTH-1:0]            camera_offset,
    output logic                            scroll_busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SCROLL = 1'b1;

    localparam logic [PHY_WIDTH-1:0] BLK_H = PHY_WIDTH'(BLOCK_HEIGHT);
    localparam logic [PHY_WIDTH-1:0] STEP  = PHY_WIDTH'(SCROLL_STEP);

    // frame-latched object registers
    logic [OBJ_NUM*PHY_WIDTH-1:0]   sh_x_q;
    logic [OBJ_NUM*PHY_WIDTH-1:0]   sh_y_q;
    logic [OBJ_NUM*SIZE_WIDTH-1:0]  sh_w_q;
    logic [OBJ_NUM*SIZE_WIDTH-1:0]  sh_h_q;
    logic [OBJ_NUM*PIXEL_WIDTH-1:0] sh_color_q;
    logic [OBJ_NUM-1:0]             sh_en_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_w_q     <= '0;
            sh_h_q     <= '0;
            sh_color_q <= '0;
            sh_en_q    <= '0;
        end else if (frame_start) begin
            sh_x_q     <= obj_x;
            sh_y_q     <= obj_y;
            sh_w_q     <= obj_w;
            sh_h_q     <= obj_h;
            sh_color_q <= obj_color;
            sh_en_q    <= obj_en;
        end
    end

    // camera scroll
    logic [0:0]           cam_st_q, cam_st_d;
    logic [PHY_WIDTH-1:0] cam_off_q, cam_off_d;
    logic [PHY_WIDTH-1:0] target;
    logic [PHY_WIDTH-1:0] diff;
    logic [PHY_WIDTH-1:0] step;
    logic                 move_up;

    always_comb begin
        target = PHY_WIDTH'(camera_blk) * BLK_H;
        if (target >= cam_off_q) begin
            move_up = 1'b1;
            diff    = target - cam_off_q;
        end else begin
            move_up = 1'b0;
            diff    = cam_off_q - target;
        end
        step = (diff > STEP) ? STEP : diff;
        cam_off_d = move_up ? (cam_off_q + step) : (cam_off_q - step);
        cam_st_d  = cam_st_q;
        if (frame_start) begin
            cam_st_d = (cam_off_d != target) ? ST_SCROLL : ST_IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cam_st_q  <= ST_IDLE;
            cam_off_q <= '0;
        end else begin
            cam_st_q <= cam_st_d;
            if (frame_start) begin
                cam_off_q <= cam_off_d;
            end
        end
    end

    assign camera_offset = cam_off_q;
    assign scroll_busy   = (cam_st_q == ST_SCROLL);

    // stage 1: screen to world translation
    logic [SCREEN_WIDTH-1:0] s1_x_q;
    logic [PHY_WIDTH-1:0]    s1_wy_q;
    logic                    s1_hs_q, s1_vs_q, s1_vo_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_x_q  <= '0;
            s1_wy_q <= '0;
            s1_hs_q <= 1'b0;
            s1_vs_q <= 1'b0;
            s1_vo_q <= 1'b0;
        end else begin
            s1_x_q  <= x;
            s1_wy_q <= PHY_WIDTH'(y) + cam_off_q;
            s1_hs_q <= hsync_in;
            s1_vs_q <= vsync_in;
            s1_vo_q <= video_on;
        end
    end

    assign map_x = s1_x_q;
    assign map_y = s1_wy_q;

    // stage 2: per-channel box test; end coordinates carry an extra bit so boxes never wrap
    function automatic logic box_hit(
        input logic                  en,
        input logic [PHY_WIDTH-1:0]  ox,
        input logic [PHY_WIDTH-1:0]  oy,
        input logic [SIZE_WIDTH-1:0] ow,
        input logic [SIZE_WIDTH-1:0] oh,
        input logic [PHY_WIDTH-1:0]  wx,
        input logic [PHY_WIDTH-1:0]  wy
    );
        logic [PHY_WIDTH:0] x_end;
        logic [PHY_WIDTH:0] y_end;
        x_end = {1'b0, ox} + (PHY_WIDTH+1)'(ow);
        y_end = {1'b0, oy} + (PHY_WIDTH+1)'(oh);
        return en && (wx >= ox) && ({1'b0, wx} < x_end)
                  && (wy >= oy) && ({1'b0, wy} < y_end);
    endfunction

    logic [OBJ_NUM-1:0] hit_d;

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < OBJ_NUM; i++) begin
            hit_d[i] = box_hit(sh_en_q[i],
                               sh_x_q[i*PHY_WIDTH +: PHY_WIDTH],
                               sh_y_q[i*PHY_WIDTH +: PHY_WIDTH],
                               sh_w_q[i*SIZE_WIDTH +: SIZE_WIDTH],
                               sh_h_q[i*SIZE_WIDTH +: SIZE_WIDTH],
                               PHY_WIDTH'(s1_x_q),
                               s1_wy_q);
        end
    end

    logic [OBJ_NUM-1:0]     s2_hit_q;
    logic [PIXEL_WIDTH-1:0] s2_map_q;
    logic                   s2_hs_q, s2_vs_q, s2_vo_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s2_hit_q <= '0;
            s2_map_q <= '0;
            s2_hs_q  <= 1'b0;
            s2_vs_q  <= 1'b0;
            s2_vo_q  <= 1'b0;
        end else begin
            s2_hit_q <= hit_d;
            s2_map_q <= map_rgb;
            s2_hs_q  <= s1_hs_q;
            s2_vs_q  <= s1_vs_q;
            s2_vo_q  <= s1_vo_q;
        end
    end

    // stage 3: priority select, walking down so channel 0 wins
    logic [PIXEL_WIDTH-1:0] sprite_rgb;
    logic [PIXEL_WIDTH-1:0] rgb_d;

    always_comb begin
        sprite_rgb = '0;
        for (int i = OBJ_NUM-1; i >= 0; i--) begin
            if (s2_hit_q[i]) begin
                sprite_rgb = sh_color_q[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
        if (!s2_vo_q) begin
            rgb_d = '0;
        end else if (|s2_hit_q) begin
            rgb_d = sprite_rgb;
        end else begin
            rgb_d = s2_map_q;
        end
    end

    logic [PIXEL_WIDTH-1:0] rgb_q;
    logic                   hs_q, vs_q, vo_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rgb_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            vo_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= s2_hs_q;
            vs_q  <= s2_vs_q;
            vo_q  <= s2_vo_q;
        end
    end

    assign rgb          = rgb_q;
    assign hsync_out    = hs_q;
    assign vsync_out    = vs_q;
    assign video_on_out = vo_q;

endmodule

// File: tb/tb_layered_pixel_compositor.sv
// Directed bench for layered_pixel_compositor; map layer is a fixed function of map_x/map_y.
module tb_layered_pixel_compositor;

    logic         sys_clk = 1'b0;
    logic         sys_rst, frame_start, video_on, hsync_in, vsync_in;
    logic [9:0]   x, y;
    logic [4:0]   camera_blk;
    logic [111:0] obj_x, obj_y;
    logic [47:0]  obj_w, obj_h;
    logic [95:0]  obj_color;
    logic [7:0]   obj_en;
    logic [9:0]   map_x;
    logic [13:0]  map_y;
    logic [11:0]  map_rgb;
    logic [11:0]  rgb;
    logic         hsync_out, vsync_out, video_on_out;
    logic [13:0]  camera_offset;
    logic         scroll_busy;

    int ncomp = 0;
    int nfail = 0;

    always #5 sys_clk = ~sys_clk;

    layered_pixel_compositor dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .frame_start(frame_start),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x(x), .y(y), .camera_blk(camera_blk),
        .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
        .obj_color(obj_color), .obj_en(obj_en),
        .map_x(map_x), .map_y(map_y), .map_rgb(map_rgb),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .video_on_out(video_on_out), .camera_offset(camera_offset),
        .scroll_busy(scroll_busy)
    );

    function automatic logic [11:0] mapc(input logic [13:0] wy, input logic [9:0] px);
        return {wy[5:0] ^ 6'h2A, px[5:0]};
    endfunction

    assign map_rgb = mapc(map_y, map_x);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic pix(input string tag, input logic [9:0] px, input logic [9:0] py,
                       input logic vo, input logic [11:0] exp);
        x = px;
        y = py;
        video_on = vo;
        tick(3);
        chk(tag, {20'd0, rgb}, {20'd0, exp});
    endtask

    task automatic set_obj(input int i, input logic [13:0] ox, input logic [13:0] oy,
                           input logic [5:0] ow, input logic [5:0] oh,
                           input logic [11:0] col, input logic en);
        obj_x[i*14 +: 14]    = ox;
        obj_y[i*14 +: 14]    = oy;
        obj_w[i*6 +: 6]      = ow;
        obj_h[i*6 +: 6]      = oh;
        obj_color[i*12 +: 12] = col;
        obj_en[i]            = en;
    endtask

    initial begin
        sys_rst = 1'b1; frame_start = 1'b0; video_on = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b0; x = '0; y = '0; camera_blk = '0;
        obj_x = '0; obj_y = '0; obj_w = '0; obj_h = '0; obj_color = '0; obj_en = '0;

        // reset and first-pixel latency
        tick(2);
        chk("rst_rgb", {20'd0, rgb}, 32'h0);
        chk("rst_hs", {31'd0, hsync_out}, 32'h0);
        chk("rst_off", {18'd0, camera_offset}, 32'h0);
        chk("rst_busy", {31'd0, scroll_busy}, 32'h0);
        sys_rst = 1'b0;
        tick(1);
        chk("lat1_rgb", {20'd0, rgb}, 32'h0);
        tick(1);
        chk("lat2_rgb", {20'd0, rgb}, 32'h0);
        tick(1);
        chk("lat3_rgb", {20'd0, rgb}, 32'hA80);
        chk("lat3_hs", {31'd0, hsync_out}, 32'h1);
        chk("lat3_vo", {31'd0, video_on_out}, 32'h1);

        // two overlapping sprites, channel 0 wins
        set_obj(0, 14'd100, 14'd50, 6'd8, 6'd8, 12'hF00, 1'b1);
        set_obj(1, 14'd100, 14'd50, 6'd8, 6'd8, 12'h0F0, 1'b1);
        pix("pre_frame", 10'd100, 10'd50, 1'b1, mapc(14'd50, 10'd100));
        pulse_frame();
        pix("hit_tl", 10'd100, 10'd50, 1'b1, 12'hF00);
        pix("hit_br", 10'd107, 10'd57, 1'b1, 12'hF00);
        pix("miss_r", 10'd108, 10'd50, 1'b1, mapc(14'd50, 10'd108));
        pix("miss_b", 10'd100, 10'd58, 1'b1, mapc(14'd58, 10'd100));
        pix("miss_l", 10'd99, 10'd50, 1'b1, mapc(14'd50, 10'd99));

        // zero width and right-edge sprites never hit or wrap
        set_obj(2, 14'd10, 14'd10, 6'd0, 6'd8, 12'h00F, 1'b1);
        set_obj(3, 14'h3FFF, 14'd0, 6'd63, 6'd63, 12'hFFF, 1'b1);
        pulse_frame();
        pix("w0_nohit", 10'd10, 10'd10, 1'b1, mapc(14'd10, 10'd10));
        pix("nowrap_0", 10'd0, 10'd0, 1'b1, mapc(14'd0, 10'd0));
        pix("nowrap_62", 10'd62, 10'd5, 1'b1, mapc(14'd5, 10'd62));

        // mid-frame object move is deferred
        set_obj(0, 14'd200, 14'd50, 6'd8, 6'd8, 12'hF00, 1'b1);
        pix("defer_old", 10'd100, 10'd50, 1'b1, 12'hF00);
        pix("defer_new", 10'd200, 10'd50, 1'b1, mapc(14'd50, 10'd200));
        pulse_frame();
        pix("moved_new", 10'd200, 10'd50, 1'b1, 12'hF00);
        pix("moved_ch1", 10'd100, 10'd50, 1'b1, 12'h0F0);

        // blanking forces black; sync delay path
        hsync_in = 1'b0; vsync_in = 1'b1;
        pix("blank_rgb", 10'd200, 10'd50, 1'b0, 12'h000);
        chk("blank_vo", {31'd0, video_on_out}, 32'h0);
        chk("sync_hs", {31'd0, hsync_out}, 32'h0);
        chk("sync_vs", {31'd0, vsync_out}, 32'h1);

        // camera scroll from block 0 to block 1
        camera_blk = 5'd1;
        for (int i = 1; i <= 30; i++) begin
            pulse_frame();
            chk($sformatf("scroll_off_%0d", i), {18'd0, camera_offset}, i * 16);
            chk($sformatf("scroll_busy_%0d", i), {31'd0, scroll_busy}, (i < 30) ? 32'h1 : 32'h0);
        end
        pix("cam_map", 10'd0, 10'd0, 1'b1, mapc(14'd480, 10'd0));
        pix("cam_nohit", 10'd100, 10'd50, 1'b1, mapc(14'd530, 10'd100));

        // target change mid-scroll takes effect only at the next pulse
        camera_blk = 5'd0;
        pulse_frame();
        chk("back_off", {18'd0, camera_offset}, 32'd464);
        chk("back_busy", {31'd0, scroll_busy}, 32'h1);
        camera_blk = 5'd1;
        tick(5);
        chk("hold_off", {18'd0, camera_offset}, 32'd464);
        pulse_frame();
        chk("ret_off", {18'd0, camera_offset}, 32'd480);
        chk("ret_busy", {31'd0, scroll_busy}, 32'h0);
        x = 10'd7; y = 10'd5;
        tick(1);
        chk("map_x", {22'd0, map_x}, 32'd7);
        chk("map_y", {18'd0, map_y}, 32'd485);

        // reset in the middle of a line
        pix("pre_rst", 10'd100, 10'd50, 1'b1, mapc(14'd530, 10'd100));
        sys_rst = 1'b1;
        tick(1);
        chk("mrst_rgb", {20'd0, rgb}, 32'h0);
        chk("mrst_vo", {31'd0, video_on_out}, 32'h0);
        chk("mrst_off", {18'd0, camera_offset}, 32'h0);
        chk("mrst_mapy", {18'd0, map_y}, 32'h0);
        sys_rst = 1'b0;
        tick(2);
        chk("post_rst2", {20'd0, rgb}, 32'h0);
        tick(1);
        chk("post_rst3", {20'd0, rgb}, {20'd0, mapc(14'd50, 10'd100)});
        pix("shadow_clr", 10'd200, 10'd50, 1'b1, mapc(14'd50, 10'd200));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
